// File: rtl/axilxbar_pkg.sv
// rtl/axilxbar_pkg.sv - shared response codes and grant FSM states for the AXI-lite crossbar
package axilxbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SWITCH = 2'd2
  } grant_state_e;

endpackage

// File: rtl/axilxbar_errslave.sv
// rtl/axilxbar_errslave.sv - outstanding-request counter that doubles as the DECERR responder
module axilxbar_errslave
  import axilxbar_pkg::*;
#(
  parameter int LGMAXBURST = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_accept,
  input  logic       i_ack,
  output logic       o_full,
  output logic       o_pending,
  output logic [1:0] o_err_bresp
);

  localparam logic [LGMAXBURST-1:0] ONE = {{(LGMAXBURST-1){1'b0}}, 1'b1};

  logic [LGMAXBURST-1:0] r_count;

  // Simultaneous accept and ack cancel out; callers guarantee no wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_accept && !i_ack) begin
      r_count <= r_count + ONE;
    end else if (!i_accept && i_ack) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_full      = &r_count;
  assign o_pending   = |r_count;
  assign o_err_bresp = RESP_DECERR;

endmodule

// File: rtl/axilxbar_mgrant.sv
// rtl/axilxbar_mgrant.sv - per-master sticky slave grant with outstanding tracking and response mux
module axilxbar_mgrant
  import axilxbar_pkg::*;
#(
  parameter int NS         = 8,
  parameter int AW         = 32,
  parameter int DW         = 32 + 32/8 + 1 + 1,
  parameter int LGMAXBURST = 3
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_stall,
  input  logic [NS:0]     i_decode,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_data,
  output logic            o_valid,
  input  logic            i_stall,
  output logic [NS:0]     o_grant,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  input  logic [NS-1:0]   i_bvalid,
  input  logic [2*NS-1:0] i_bresp,
  output logic [NS-1:0]   o_bready,
  output logic            o_bvalid,
  output logic [1:0]      o_bresp,
  input  logic            i_bready
);

  grant_state_e r_state, w_state_next;
  logic [NS:0]  r_grant, w_grant_next;
  logic         w_full, w_pending, w_accept, w_ack;
  logic         w_active, w_match, w_none;
  logic [1:0]   w_err_bresp;

  assign o_grant  = r_grant;
  assign o_addr   = i_addr;
  assign o_data   = i_data;

  assign w_active = (r_state == ST_ACTIVE);
  assign w_match  = (i_decode == r_grant);
  assign w_none   = r_grant[NS];

  assign o_valid  = i_valid && w_active && w_match && !w_none && !w_full;
  // The none-slave grant never reaches a real slave, so it ignores i_stall.
  assign w_accept = w_none ? (i_valid && w_active && i_decode[NS] && !w_full)
                           : (o_valid && !i_stall);
  assign o_stall  = i_valid && !w_accept;
  assign w_ack    = o_bvalid && i_bready;

  axilxbar_errslave #(
    .LGMAXBURST (LGMAXBURST)
  ) u_errslave (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_accept    (w_accept),
    .i_ack       (w_ack),
    .o_full      (w_full),
    .o_pending   (w_pending),
    .o_err_bresp (w_err_bresp)
  );

  // IDLE holds a zero grant, so every output below collapses to zero there.
  always_comb begin
    o_bvalid = 1'b0;
    o_bresp  = 2'b00;
    o_bready = '0;
    if (w_none) begin
      o_bvalid = w_pending;
      o_bresp  = w_err_bresp;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (r_grant[s]) begin
          o_bvalid    = i_bvalid[s] && w_pending;
          o_bresp     = i_bresp[2*s +: 2];
          o_bready[s] = i_bready && w_pending;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_grant_next = i_decode;
          w_state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Retarget immediately only when nothing is in flight to the old slave.
        if (i_valid && !w_match) begin
          if (w_pending) w_state_next = ST_SWITCH;
          else           w_grant_next = i_decode;
        end
      end
      ST_SWITCH: begin
        if (!w_pending) begin
          if (i_valid) begin
            w_grant_next = i_decode;
            w_state_next = ST_ACTIVE;
          end else begin
            w_grant_next = '0;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axilxbar_mgrant.sv
// tb/tb_axilxbar_mgrant.sv - self-checking bench for axilxbar_mgrant
module tb_axilxbar_mgrant;

  localparam int NS   = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LGMB = 2;
  localparam int MAXO = (1 << LGMB) - 1;

  logic          clk, rst;
  logic          vld, stl, br;
  logic [NS:0]   dec;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [NS-1:0] bv;
  logic [2*NS-1:0] bresp;
  logic          w_stall, w_valid, w_bvalid;
  logic [NS:0]   w_grant;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [NS-1:0] w_bready;
  logic [1:0]    w_bresp;

  int n_cmp = 0;
  int n_err = 0;

  axilxbar_mgrant #(.NS(NS), .AW(AW), .DW(DW), .LGMAXBURST(LGMB)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_stall(w_stall),
    .i_decode(dec), .i_addr(addr), .i_data(data), .o_valid(w_valid),
    .i_stall(stl), .o_grant(w_grant), .o_addr(w_addr), .o_data(w_data),
    .i_bvalid(bv), .i_bresp(bresp), .o_bready(w_bready), .o_bvalid(w_bvalid),
    .o_bresp(w_bresp), .i_bready(br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic vld; logic [4:0] dec; logic stl; logic [3:0] bv; logic br;
    logic e_stall; logic e_valid; logic [4:0] e_grant;
    logic e_bvalid; logic [1:0] e_bresp; logic [3:0] e_bready;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] d, logic s, logic [3:0] b, logic r,
                              logic es, logic ev, logic [4:0] eg, logic eb,
                              logic [1:0] er, logic [3:0] ey);
    vec_t t;
    t.vld = v; t.dec = d; t.stl = s; t.bv = b; t.br = r;
    t.e_stall = es; t.e_valid = ev; t.e_grant = eg;
    t.e_bvalid = eb; t.e_bresp = er; t.e_bready = ey;
    return t;
  endfunction

  // Reference model: mode 0 idle / 1 granted / 2 draining, queue of in-flight targets.
  int m_mode;
  int m_g;
  int m_q[$];

  vec_t tbl[20];

  initial begin
    rst = 1'b1; vld = 0; stl = 0; br = 0; dec = '0; bv = '0;
    bresp = 8'b00_00_10_00; addr = '0; data = '0;

    //           vld dec       stl bv      br   stall valid grant     bval bresp  bready
    tbl[0]  = mk(1, 5'b00010, 0, 4'b0000, 0,   1, 0, 5'b00000, 0, 2'b00, 4'b0000);
    tbl[1]  = mk(1, 5'b00010, 0, 4'b0000, 0,   0, 1, 5'b00010, 0, 2'b10, 4'b0000);
    tbl[2]  = mk(1, 5'b00010, 0, 4'b0000, 0,   0, 1, 5'b00010, 0, 2'b10, 4'b0000);
    tbl[3]  = mk(1, 5'b00010, 0, 4'b0000, 0,   0, 1, 5'b00010, 0, 2'b10, 4'b0000);
    tbl[4]  = mk(1, 5'b00010, 0, 4'b0000, 0,   1, 0, 5'b00010, 0, 2'b10, 4'b0000);
    tbl[5]  = mk(0, 5'b00010, 0, 4'b0010, 1,   0, 0, 5'b00010, 1, 2'b10, 4'b0010);
    tbl[6]  = mk(1, 5'b00100, 0, 4'b0000, 0,   1, 0, 5'b00010, 0, 2'b10, 4'b0000);
    tbl[7]  = mk(1, 5'b00100, 0, 4'b0010, 1,   1, 0, 5'b00010, 1, 2'b10, 4'b0010);
    tbl[8]  = mk(1, 5'b00100, 0, 4'b0010, 1,   1, 0, 5'b00010, 1, 2'b10, 4'b0010);
    tbl[9]  = mk(1, 5'b00100, 0, 4'b0000, 1,   1, 0, 5'b00010, 0, 2'b10, 4'b0000);
    tbl[10] = mk(1, 5'b00100, 0, 4'b0000, 0,   0, 1, 5'b00100, 0, 2'b00, 4'b0000);
    tbl[11] = mk(1, 5'b00100, 0, 4'b0100, 1,   0, 1, 5'b00100, 1, 2'b00, 4'b0100);
    tbl[12] = mk(0, 5'b00100, 0, 4'b0100, 1,   0, 0, 5'b00100, 1, 2'b00, 4'b0100);
    tbl[13] = mk(0, 5'b00100, 0, 4'b0100, 1,   0, 0, 5'b00100, 0, 2'b00, 4'b0000);
    tbl[14] = mk(1, 5'b10000, 0, 4'b0000, 0,   1, 0, 5'b00100, 0, 2'b00, 4'b0000);
    tbl[15] = mk(1, 5'b10000, 1, 4'b0000, 0,   0, 0, 5'b10000, 0, 2'b11, 4'b0000);
    tbl[16] = mk(1, 5'b10000, 0, 4'b0000, 0,   0, 0, 5'b10000, 1, 2'b11, 4'b0000);
    tbl[17] = mk(0, 5'b10000, 0, 4'b1111, 1,   0, 0, 5'b10000, 1, 2'b11, 4'b0000);
    tbl[18] = mk(0, 5'b10000, 0, 4'b1111, 1,   0, 0, 5'b10000, 1, 2'b11, 4'b0000);
    tbl[19] = mk(0, 5'b10000, 0, 4'b1111, 1,   0, 0, 5'b10000, 0, 2'b11, 4'b0000);

    repeat (2) @(negedge clk);
    rst = 1'b0; bv = 4'b1111; br = 1'b1;
    #1;
    chk("reset grant",  32'(w_grant),  0);
    chk("reset valid",  32'(w_valid),  0);
    chk("reset bvalid", 32'(w_bvalid), 0);
    chk("reset bready", 32'(w_bready), 0);
    chk("reset bresp",  32'(w_bresp),  0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vld = tbl[i].vld; dec = tbl[i].dec; stl = tbl[i].stl; bv = tbl[i].bv; br = tbl[i].br;
      #1;
      chk($sformatf("row%0d stall", i),  32'(w_stall),  32'(tbl[i].e_stall));
      chk($sformatf("row%0d valid", i),  32'(w_valid),  32'(tbl[i].e_valid));
      chk($sformatf("row%0d grant", i),  32'(w_grant),  32'(tbl[i].e_grant));
      chk($sformatf("row%0d bvalid", i), 32'(w_bvalid), 32'(tbl[i].e_bvalid));
      chk($sformatf("row%0d bresp", i),  32'(w_bresp),  32'(tbl[i].e_bresp));
      chk($sformatf("row%0d bready", i), 32'(w_bready), 32'(tbl[i].e_bready));
    end

    // Two DECERR requests in flight, then reset without a clock edge.
    repeat (2) begin
      @(negedge clk);
      vld = 1; dec = 5'b10000; stl = 0; bv = '0; br = 0;
    end
    @(negedge clk);
    vld = 0; bv = 4'b1111; br = 0;
    #1;
    chk("pre-reset bvalid", 32'(w_bvalid), 1);
    rst = 1'b1;
    #1;
    chk("async grant",  32'(w_grant),  0);
    chk("async bvalid", 32'(w_bvalid), 0);
    chk("async bready", 32'(w_bready), 0);
    chk("async bresp",  32'(w_bresp),  0);
    @(negedge clk);
    rst = 1'b0; vld = 1; dec = 5'b00010; br = 1;
    #1;
    chk("post-reset stall", 32'(w_stall), 1);
    chk("post-reset valid", 32'(w_valid), 0);
    @(negedge clk);
    #1;
    chk("post-reset grant",  32'(w_grant),  32'(5'b00010));
    chk("post-reset valid2", 32'(w_valid),  1);
    chk("post-reset bvalid", 32'(w_bvalid), 0);

    @(negedge clk);
    rst = 1'b1; vld = 0;
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0; m_g = 0; m_q.delete();

    for (int c = 0; c < 3000; c++) begin
      int d, cnt, g;
      logic full, acc, ack, e_valid, e_stall, e_bvalid;
      logic [1:0] e_bresp;
      logic [NS-1:0] e_bready;
      logic [NS:0] e_grant;
      @(negedge clk);
      vld = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) != 0) ? $clog2(32'(dec) + 0) : int'($urandom_range(0, NS));
      if (dec == '0 || (1 << d) != int'(dec)) d = int'($urandom_range(0, NS));
      dec = (NS+1)'(1 << d);
      stl = ($urandom_range(0, 3) == 0);
      bv = NS'($urandom);
      bresp = (2*NS)'($urandom);
      br = ($urandom_range(0, 2) != 0);
      addr = AW'($urandom);
      data = DW'($urandom);
      #1;
      g = m_g;
      cnt = m_q.size();
      full = (cnt == MAXO);
      e_grant = (m_mode == 0) ? '0 : (NS+1)'(1 << g);
      e_valid = vld && m_mode == 1 && d == g && g < NS && !full;
      acc = vld && m_mode == 1 && d == g && !full && (g == NS || !stl);
      e_stall = vld && !acc;
      e_bvalid = 0; e_bresp = 2'b00; e_bready = '0;
      if (m_mode != 0 && g < NS) begin
        e_bvalid = bv[g] && cnt > 0;
        e_bresp = bresp[2*g +: 2];
        if (br && cnt > 0) e_bready = NS'(1 << g);
      end else if (m_mode != 0) begin
        e_bvalid = (cnt > 0);
        e_bresp = 2'b11;
      end
      ack = e_bvalid && br;
      chk($sformatf("rnd%0d stall", c),  32'(w_stall),  32'(e_stall));
      chk($sformatf("rnd%0d valid", c),  32'(w_valid),  32'(e_valid));
      chk($sformatf("rnd%0d grant", c),  32'(w_grant),  32'(e_grant));
      chk($sformatf("rnd%0d bvalid", c), 32'(w_bvalid), 32'(e_bvalid));
      chk($sformatf("rnd%0d bresp", c),  32'(w_bresp),  32'(e_bresp));
      chk($sformatf("rnd%0d bready", c), 32'(w_bready), 32'(e_bready));
      chk($sformatf("rnd%0d addr", c),   32'(w_addr),   32'(addr));
      chk($sformatf("rnd%0d data", c),   32'(w_data),   32'(data));
      if (acc) m_q.push_back(g);
      if (ack) void'(m_q.pop_front());
      if (m_mode == 0) begin
        if (vld) begin m_g = d; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (vld && d != g) begin
          if (cnt > 0) m_mode = 2;
          else m_g = d;
        end
      end else if (cnt == 0) begin
        if (vld) begin m_g = d; m_mode = 1; end
        else m_mode = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
